tube_event_builder: RTL and testbench

//  Parametrised drift-tube event builder. Captures first-hit time of N_CH tube channels within a fixed window

---
 rtl/tube_event_builder_pkg.sv | 17 +
 rtl/tube_event_builder_hit_capture.sv | 48 ++++
 rtl/tube_event_builder.sv | 185 ++++++++++++++++++
 tb/tb_tube_event_builder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_event_builder_pkg.sv
// Shared definitions for the drift-tube event builder and its readout decoder.
package qn_evt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACQ,
        DRAIN,
        TRAIL,
        DEAD
    } evt_state_e;

    // All-ones time field: channel not hit (or hit in the last window cycle).
    localparam logic [31:0] NO_HIT_TIME = '1;
    // All-ones id field: never a channel number, reserved for the trailer.
    localparam logic [31:0] TRAILER_ID  = '1;

endpackage

// File: rtl/tube_event_builder_hit_capture.sv
// Per-channel rising-edge detector and first-hit time latch.
module hit_capture #(
    parameter int unsigned TIME_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              arm,
    input  logic              en,
    input  logic              hit,
    input  logic [TIME_W-1:0] win_cnt,
    output logic              hit_valid,
    output logic [TIME_W-1:0] hit_time
);

    logic              hit_prev_q, hit_prev_d;
    logic              valid_q, valid_d;
    logic [TIME_W-1:0] time_q, time_d;

    // Latch the window count on the first rising edge seen while enabled.
    always_comb begin
        hit_prev_d = hit;
        valid_d    = valid_q;
        time_d     = time_q;
        if (arm) begin
            valid_d = 1'b0;
        end else if (en && hit && !hit_prev_q && !valid_q) begin
            valid_d = 1'b1;
            time_d  = win_cnt;
        end
    end

    // State registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            hit_prev_q <= 1'b0;
            valid_q    <= 1'b0;
            time_q     <= '0;
        end else begin
            hit_prev_q <= hit_prev_d;
            valid_q    <= valid_d;
            time_q     <= time_d;
        end
    end

    assign hit_valid = valid_q;
    assign hit_time  = time_q;

endmodule

// File: rtl/tube_event_builder.sv
// Drift-tube event builder: windowed first-hit capture, then one record per
// channel plus a trailer on a valid/ready stream behind a one-word register.
module tube_event_builder
    import qn_evt_pkg::*;
#(
    parameter int unsigned N_CH    = 32,
    parameter int unsigned TIME_W  = 8,
    parameter int unsigned ID_W    = 8,
    parameter int unsigned WINDOW  = 256,
    parameter int unsigned HOLDOFF = 16
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   trig,
    input  logic [N_CH-1:0]        hits,
    input  logic                   zs_en,
    output logic [TIME_W+ID_W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [15:0]            evt_cnt,
    output logic [15:0]            dropped_cnt
);

    localparam int unsigned W    = TIME_W + ID_W;
    localparam int unsigned HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    evt_state_e        state_q, state_d;
    logic              trig_q, trig_d;
    logic [TIME_W-1:0] win_cnt_q, win_cnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [HO_W-1:0]   dead_cnt_q, dead_cnt_d;
    logic              zs_q, zs_d;
    logic              trail_sent_q, trail_sent_d;
    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_data_q, out_data_d;
    logic [15:0]       evt_cnt_q, evt_cnt_d;
    logic [15:0]       dropped_cnt_q, dropped_cnt_d;

    logic              trig_edge, arm, acq;
    logic [N_CH-1:0]   hit_valid;
    logic [TIME_W-1:0] hit_time [N_CH];
    logic              sel_valid;
    logic [TIME_W-1:0] sel_time;
    logic              load_ok, has_word;

    assign trig_edge = trig & ~trig_q;
    assign arm       = (state_q == IDLE) & trig_edge;
    assign acq       = (state_q == ACQ);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        hit_capture #(.TIME_W(TIME_W)) u_cap (
            .clk      (clk),
            .clr      (clr),
            .arm      (arm),
            .en       (acq),
            .hit      (hits[c]),
            .win_cnt  (win_cnt_q),
            .hit_valid(hit_valid[c]),
            .hit_time (hit_time[c])
        );
    end

    // Select the latch addressed by the scan pointer.
    always_comb begin
        sel_valid = 1'b0;
        sel_time  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ptr_q == ID_W'(i)) begin
                sel_valid = hit_valid[i];
                sel_time  = hit_time[i];
            end
        end
    end

    // Next-state, counters and output register; a new word loads when the
    // register is empty or being accepted this cycle.
    always_comb begin
        state_d       = state_q;
        trig_d        = trig;
        win_cnt_d     = win_cnt_q;
        ptr_d         = ptr_q;
        dead_cnt_d    = dead_cnt_q;
        zs_d          = zs_q;
        trail_sent_d  = trail_sent_q;
        out_valid_d   = out_valid_q & ~out_ready;
        out_data_d    = out_data_q;
        evt_cnt_d     = evt_cnt_q;
        dropped_cnt_d = dropped_cnt_q;
        load_ok       = ~out_valid_q | out_ready;
        has_word      = sel_valid | ~zs_q;

        if (trig_edge && (state_q != IDLE) && (dropped_cnt_q != '1))
            dropped_cnt_d = dropped_cnt_q + 16'd1;

        case (state_q)
            IDLE: begin
                if (trig_edge) begin
                    state_d   = ACQ;
                    win_cnt_d = '0;
                    zs_d      = zs_en;
                end
            end
            ACQ: begin
                if (win_cnt_q == TIME_W'(WINDOW - 1)) begin
                    state_d = DRAIN;
                    ptr_d   = '0;
                end else begin
                    win_cnt_d = win_cnt_q + TIME_W'(1);
                end
            end
            DRAIN: begin
                if (!has_word || load_ok) begin
                    if (has_word) begin
                        out_valid_d = 1'b1;
                        out_data_d  = {sel_valid ? sel_time : NO_HIT_TIME[TIME_W-1:0], ptr_q};
                    end
                    if (ptr_q == ID_W'(N_CH - 1)) begin
                        state_d      = TRAIL;
                        ptr_d        = TRAILER_ID[ID_W-1:0];
                        trail_sent_d = 1'b0;
                    end else begin
                        ptr_d = ptr_q + ID_W'(1);
                    end
                end
            end
            TRAIL: begin
                if (!trail_sent_q) begin
                    if (load_ok) begin
                        out_valid_d  = 1'b1;
                        out_data_d   = {NO_HIT_TIME[TIME_W-1:0], evt_cnt_q[ID_W-1:0]};
                        trail_sent_d = 1'b1;
                    end
                end else if (out_valid_q && out_ready) begin
                    evt_cnt_d  = evt_cnt_q + 16'd1;
                    state_d    = DEAD;
                    dead_cnt_d = '0;
                end
            end
            DEAD: begin
                if (dead_cnt_q == HO_W'(HOLDOFF - 1))
                    state_d = IDLE;
                else
                    dead_cnt_d = dead_cnt_q + HO_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= IDLE;
            trig_q        <= 1'b0;
            win_cnt_q     <= '0;
            ptr_q         <= '0;
            dead_cnt_q    <= '0;
            zs_q          <= 1'b0;
            trail_sent_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            evt_cnt_q     <= '0;
            dropped_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            trig_q        <= trig_d;
            win_cnt_q     <= win_cnt_d;
            ptr_q         <= ptr_d;
            dead_cnt_q    <= dead_cnt_d;
            zs_q          <= zs_d;
            trail_sent_q  <= trail_sent_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            evt_cnt_q     <= evt_cnt_d;
            dropped_cnt_q <= dropped_cnt_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q != IDLE);
    assign evt_cnt     = evt_cnt_q;
    assign dropped_cnt = dropped_cnt_q;

endmodule

// File: tb/tb_tube_event_builder.sv
// Bench for tube_event_builder: per-cycle hit level tables, expected record
// lists derived from first rising edges in the window, stream monitor.
module tb_tube_event_builder;

    localparam int N_CH    = 32;
    localparam int TIME_W  = 8;
    localparam int ID_W    = 8;
    localparam int WINDOW  = 256;
    localparam int HOLDOFF = 16;
    localparam int W       = TIME_W + ID_W;

    logic              clk = 1'b0;
    logic              clr, trig, zs_en, out_ready;
    logic [N_CH-1:0]   hits;
    logic [W-1:0]      out_data;
    logic              out_valid, busy;
    logic [15:0]       evt_cnt, dropped_cnt;

    int                n_total = 0;
    int                n_bad   = 0;
    int                cyc     = 0;
    int                t_cyc   = 0;
    int                trl_cyc = 0;
    bit                mon_en  = 1'b0;
    logic [W-1:0]      exp_q[$];
    logic [N_CH-1:0]   lvl [WINDOW+1];
    logic [15:0]       evt_model  = '0;
    logic [15:0]       drop_model = '0;

    tube_event_builder #(
        .N_CH   (N_CH),
        .TIME_W (TIME_W),
        .ID_W   (ID_W),
        .WINDOW (WINDOW),
        .HOLDOFF(HOLDOFF)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .trig       (trig),
        .hits       (hits),
        .zs_en      (zs_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .evt_cnt    (evt_cnt),
        .dropped_cnt(dropped_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ready(input int rmode);
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom);
            default: out_ready = 1'b0;
        endcase
    endtask

    // lvl[0] is the trigger cycle, lvl[k+1] the cycle with window count k.
    task automatic gen_hits(input bit rnd);
        int dens;
        for (int j = 0; j <= WINDOW; j++) lvl[j] = '0;
        if (rnd) begin
            for (int c = 0; c < N_CH; c++) begin
                case ($urandom % 4)
                    0:       dens = 0;
                    1:       dens = 1;
                    2:       dens = 4;
                    default: dens = 30;
                endcase
                for (int j = 0; j <= WINDOW; j++)
                    lvl[j][c] = (($urandom % 100) < dens);
            end
        end
    endtask

    task automatic build_expect(input bit zs);
        for (int c = 0; c < N_CH; c++) begin
            int first;
            first = -1;
            for (int k = 0; k < WINDOW; k++)
                if (first < 0 && lvl[k+1][c] && !lvl[k][c]) first = k;
            if (first >= 0)
                exp_q.push_back({TIME_W'(first), ID_W'(c)});
            else if (!zs)
                exp_q.push_back({{TIME_W{1'b1}}, ID_W'(c)});
        end
        exp_q.push_back({{TIME_W{1'b1}}, evt_model[ID_W-1:0]});
        evt_model = evt_model + 16'd1;
    endtask

    task automatic monitor();
        bit           prev_stall;
        logic [W-1:0] prev_data;
        logic [W-1:0] w;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_eq("hold_valid", 32'(out_valid), 32'd1);
                    check_eq("hold_data", 32'(out_data), 32'(prev_data));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_word", 32'(out_valid & out_ready), 32'd0);
                    end else begin
                        w = exp_q.pop_front();
                        check_eq("word", 32'(out_data), 32'(w));
                        if (exp_q.size() == 0) trl_cyc = cyc;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    endtask

    task automatic run_event(input bit zs, input int rmode, input int n_drop,
                             input bit hold_trig, input bit abort_clr, input bit chk_lat);
        int drops_left;
        int dcyc;
        bit done;
        drops_left = n_drop;
        dcyc       = 0;
        done       = 1'b0;
        build_expect(zs);
        if (abort_clr) mon_en = 1'b0;
        step();
        trig  = 1'b1;
        hits  = lvl[0];
        zs_en = zs;
        drive_ready(rmode);
        t_cyc = cyc;
        for (int k = 0; k < WINDOW; k++) begin
            step();
            hits  = lvl[k+1];
            zs_en = 1'($urandom);
            drive_ready(rmode);
            if (!hold_trig && k >= 1) trig = 1'b0;
        end
        while (!done && dcyc < 3000) begin
            step();
            dcyc++;
            if (exp_q.size() == 0) begin
                done = 1'b1;
            end else begin
                hits  = N_CH'($urandom);
                zs_en = 1'($urandom);
                drive_ready(rmode);
                if (trig && !hold_trig) begin
                    trig = 1'b0;
                end else if (drops_left > 0 && !trig) begin
                    trig = 1'b1;
                    drops_left--;
                    if (drop_model != 16'hFFFF) drop_model = drop_model + 16'd1;
                end
                if (abort_clr && dcyc == 4) begin
                    @(negedge clk);
                    check_eq("pre_clr_valid", 32'(out_valid), 32'd1);
                    step();
                    clr  = 1'b1;
                    trig = 1'b0;
                    step();
                    clr = 1'b0;
                    @(negedge clk);
                    check_eq("clr_out_valid", 32'(out_valid), 32'd0);
                    check_eq("clr_busy", 32'(busy), 32'd0);
                    check_eq("clr_evt_cnt", 32'(evt_cnt), 32'd0);
                    check_eq("clr_dropped", 32'(dropped_cnt), 32'd0);
                    exp_q.delete();
                    evt_model  = '0;
                    drop_model = '0;
                    mon_en     = 1'b1;
                    return;
                end
            end
        end
        if (!done) begin
            check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        trig = hold_trig;
        hits = N_CH'($urandom);
        if (chk_lat)
            check_eq("trailer_latency", 32'(trl_cyc - t_cyc), 32'(WINDOW + N_CH + 2));
        @(negedge clk);
        check_eq("evt_cnt", 32'(evt_cnt), 32'(evt_model));
        check_eq("dropped_cnt", 32'(dropped_cnt), 32'(drop_model));
        check_eq("busy_dead_first", 32'(busy), 32'd1);
        for (int i = 1; i < HOLDOFF; i++) begin
            step();
            hits = N_CH'($urandom);
            drive_ready(2);
        end
        @(negedge clk);
        check_eq("busy_dead_last", 32'(busy), 32'd1);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            hits  = N_CH'($urandom);
            zs_en = 1'($urandom);
            drive_ready(2);
            if (i == n - 1) trig = 1'b0;
            @(negedge clk);
            check_eq("busy_idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        clr       = 1'b1;
        trig      = 1'b0;
        hits      = '0;
        zs_en     = 1'b0;
        out_ready = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) step();
        clr = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_evt_cnt", 32'(evt_cnt), 32'd0);
        check_eq("rst_dropped", 32'(dropped_cnt), 32'd0);
        mon_en = 1'b1;

        // ch3 at k=5, ch31 at k=255, no suppression, sink always ready
        gen_hits(1'b0);
        lvl[6][3]   = 1'b1;
        lvl[256][31] = 1'b1;
        run_event(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle_gap(2);

        // zero-suppressed: ch0 at k=0, ch7 at k=200
        gen_hits(1'b0);
        lvl[1][0]   = 1'b1;
        lvl[201][7] = 1'b1;
        run_event(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
        idle_gap(2);

        // zero-suppressed, no hits: trailer only
        gen_hits(1'b0);
        run_event(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
        idle_gap(2);

        // same pattern as the first event with the sink toggling
        gen_hits(1'b0);
        lvl[6][3]    = 1'b1;
        lvl[256][31] = 1'b1;
        run_event(1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
        idle_gap(2);

        // three triggers while busy, then a trigger in the first idle cycle
        gen_hits(1'b1);
        run_event(1'b0, 0, 3, 1'b0, 1'b0, 1'b1);
        gen_hits(1'b1);
        run_event(1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
        idle_gap(2);

        // trigger held high through the whole event must not re-arm
        gen_hits(1'b1);
        run_event(1'b0, 2, 0, 1'b1, 1'b0, 1'b0);
        idle_gap(6);

        // clear in the middle of a stalled drain, then a fresh event
        gen_hits(1'b1);
        run_event(1'b0, 3, 0, 1'b0, 1'b1, 1'b0);
        idle_gap(2);
        gen_hits(1'b1);
        run_event(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle_gap(2);

        for (int n = 0; n < 4; n++) begin
            gen_hits(1'b1);
            run_event(1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      1'b0, 1'b0, 1'b0);
            idle_gap(int'($urandom_range(1, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
